matrix_scan_loader: RTL
=======================

Name: matrix_scan_loader

Overview:
- Sequencer that fills the 16x16 dot-matrix column store one column per write, sourcing column bitmaps from an external pattern ROM at a scrolling offset.
- Drives the matrix write side: column_id, in_column, LOAD, IN_CLR.
- Sits between the top-level control (start, clear, scroll enable) and the matrix block. It owns the frame-write schedule and the horizontal scroll position.

Parameters:
- COLS, 16, columns written per frame.
- PATTERN_LEN, 32, pattern ROM depth in columns. Scroll offset wraps modulo this value; it need not be a power of two.
- ID_W, 5, width of column_id, rom_addr and scroll_ofs.
- CLR_CYCLES, 2, cycles IN_CLR is held high for a clear.
- SCROLL_DIV, 4, completed frames per scroll step.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous reset, active-high.
- start  in  1  request a frame write; sampled only in IDLE.
- clear_req  in  1  request a matrix clear; sampled only in IDLE; has priority over start.
- scroll_en  in  1  when high, completed frames count toward scroll advance.
- rom_addr  out  ID_W  pattern ROM address; ROM read latency is 1 cycle.
- rom_data  in  16  pattern ROM column bitmap.
- column_id  out  ID_W  target column index to the matrix.
- in_column  out  16  column bitmap to the matrix.
- LOAD  out  1  one-cycle write strobe to the matrix.
- IN_CLR  out  1  clear strobe to the matrix.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse when a frame write or clear completes.
- scroll_ofs  out  ID_W  current scroll offset.

Behaviour:
- Reset state: IDLE, col=0, frame_cnt=0.
- Reset values of outputs: rom_addr=0, column_id=0, in_column=0, LOAD=0, IN_CLR=0, busy=0, frame_done=0, scroll_ofs=0.
- Reset mid-operation aborts immediately:
  - no further LOAD is issued;
  - no frame_done is issued;
  - scroll_ofs returns to 0.
- All outputs are registered or decoded from state. There is no combinational path from any input to any output.
- States: IDLE, CLEAR, FETCH, LATCH, WRITE, DONE.
- IDLE:
  - clear_req=1 -> CLEAR with clr_cnt=0.
  - else start=1 -> FETCH with col=0.
  - Both high -> CLEAR; start is dropped, not queued.
- CLEAR: IN_CLR=1 for exactly CLR_CYCLES cycles, then DONE. A clear does not touch scroll_ofs or frame_cnt.
- FETCH: rom_addr = (scroll_ofs + col) mod PATTERN_LEN, computed with compare-and-subtract. 1 cycle, then -> LATCH.
- LATCH:
  - rom_data is valid this cycle.
  - At the closing edge, in_column <= rom_data and column_id <= col.
  - -> WRITE.
- WRITE: LOAD=1 for this cycle only.
  - If col == COLS-1 -> DONE.
  - Else col <= col+1 -> FETCH.
- DONE: frame_done=1 for one cycle, then -> IDLE.
- Scroll advance, applied in DONE after a frame write only:
  - If scroll_en=1: frame_cnt increments.
  - When frame_cnt reaches SCROLL_DIV-1: frame_cnt <= 0 and scroll_ofs <= (scroll_ofs+1) mod PATTERN_LEN, so PATTERN_LEN-1 wraps to 0.
  - scroll_en=0 holds both frame_cnt and scroll_ofs.
- column_id and in_column hold their last written values outside WRITE. LOAD is the only write qualifier.
- start or clear_req while busy is ignored.
- A new request is accepted on the cycle after DONE at the earliest, i.e. one IDLE cycle.
- Timing: start sampled at edge k; FETCH at cycle k+1.
  - Column c: FETCH at k+1+3c, LATCH at k+2+3c, WRITE (LOAD) at k+3+3c.
  - Last LOAD at k+48; frame_done at k+49.
  - busy is high over k+1..k+49.
- Clear timing: clear_req sampled at edge k; IN_CLR high k+1..k+CLR_CYCLES; frame_done at k+CLR_CYCLES+1.
- scroll_ofs is stable for the whole frame. It changes only at the edge leaving DONE.

Test Plan:
- Frame write: ROM model returns 16'hA500|addr, scroll_ofs=0, pulse start.
  - LOAD pulses 16 times, spaced 3 cycles apart.
  - column_id 0..15, with in_column 16'hA500..16'hA50F.
  - frame_done exactly 49 cycles after the start edge; busy low afterwards.
- Scroll and wrap: SCROLL_DIV=1, scroll_en=1, run 20 frames.
  - scroll_ofs=20.
  - In the next frame, column 12 reads addr 0 (in_column 16'hA500) and column 11 reads addr 31.
  - After 32 frames in total, scroll_ofs=0.
- Scroll divider: default SCROLL_DIV=4, scroll_en=1.
  - scroll_ofs steps 0->1 only after the 4th frame_done.
  - With scroll_en=0, 10 frames leave scroll_ofs unchanged.
- Clear priority: start and clear_req high together in IDLE.
  - IN_CLR high 2 cycles, no LOAD, frame_done at k+3.
  - scroll_ofs unchanged; the dropped start is not executed afterward.
- Busy rejection: pulse start and clear_req at cycle k+20 of an active frame.
  - Frame completes normally with exactly 16 LOADs and a single frame_done.
- Reset mid-frame: assert RESET for 1 cycle after the 7th LOAD.
  - All outputs go to 0 at the next edge, with no further LOAD and no frame_done.
  - A subsequent start writes columns 0..15 from offset 0.

Source files
------------

// File: rtl/matrix_scan_loader.sv
// Column-write sequencer for the 16x16 dot matrix.
// Streams pattern ROM columns at a scrolling offset, one column per LOAD.
module matrix_scan_loader #(
   parameter int COLS        = 16,
   parameter int PATTERN_LEN = 32,
   parameter int ID_W        = 5,
   parameter int CLR_CYCLES  = 2,
   parameter int SCROLL_DIV  = 4
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            start,
   input  logic            clear_req,
   input  logic            scroll_en,
   output logic [ID_W-1:0] rom_addr,
   input  logic [15:0]     rom_data,
   output logic [ID_W-1:0] column_id,
   output logic [15:0]     in_column,
   output logic            LOAD,
   output logic            IN_CLR,
   output logic            busy,
   output logic            frame_done,
   output logic [ID_W-1:0] scroll_ofs
);

   localparam int FC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int CC_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE, CLEAR, FETCH, LATCH, WRITE, DONE
   } state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] col_q, col_d;
   logic [CC_W-1:0] clr_q, clr_d;
   logic [FC_W-1:0] fcnt_q, fcnt_d;
   logic [ID_W-1:0] ofs_q, ofs_d;
   logic [ID_W-1:0] addr_q, addr_d;
   logic [ID_W-1:0] cid_q, cid_d;
   logic [15:0]     data_q, data_d;
   logic            was_clr_q, was_clr_d;

   // Operands stay below 2*PATTERN_LEN, so one conditional subtract wraps.
   function automatic logic [ID_W-1:0] wrap_add(
      input logic [ID_W-1:0] a,
      input logic [ID_W-1:0] b
   );
      logic [ID_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (ID_W+1)'(PATTERN_LEN))
         s = s - (ID_W+1)'(PATTERN_LEN);
      return s[ID_W-1:0];
   endfunction

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      clr_d     = clr_q;
      fcnt_d    = fcnt_q;
      ofs_d     = ofs_q;
      addr_d    = addr_q;
      cid_d     = cid_q;
      data_d    = data_q;
      was_clr_d = was_clr_q;
      unique case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLEAR;
               clr_d     = '0;
               was_clr_d = 1'b1;
            end else if (start) begin
               state_d   = FETCH;
               col_d     = '0;
               addr_d    = wrap_add(ofs_q, '0);
               was_clr_d = 1'b0;
            end
         end
         CLEAR: begin
            if (clr_q == CC_W'(CLR_CYCLES-1))
               state_d = DONE;
            else
               clr_d = clr_q + CC_W'(1);
         end
         FETCH: state_d = LATCH;
         LATCH: begin
            data_d  = rom_data;
            cid_d   = col_q;
            state_d = WRITE;
         end
         WRITE: begin
            if (col_q == ID_W'(COLS-1)) begin
               state_d = DONE;
            end else begin
               col_d   = col_q + ID_W'(1);
               addr_d  = wrap_add(ofs_q, col_q + ID_W'(1));
               state_d = FETCH;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!was_clr_q && scroll_en) begin
               if (fcnt_q == FC_W'(SCROLL_DIV-1)) begin
                  fcnt_d = '0;
                  ofs_d  = wrap_add(ofs_q, ID_W'(1));
               end else begin
                  fcnt_d = fcnt_q + FC_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         col_q     <= '0;
         clr_q     <= '0;
         fcnt_q    <= '0;
         ofs_q     <= '0;
         addr_q    <= '0;
         cid_q     <= '0;
         data_q    <= '0;
         was_clr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         clr_q     <= clr_d;
         fcnt_q    <= fcnt_d;
         ofs_q     <= ofs_d;
         addr_q    <= addr_d;
         cid_q     <= cid_d;
         data_q    <= data_d;
         was_clr_q <= was_clr_d;
      end
   end

   assign rom_addr   = addr_q;
   assign column_id  = cid_q;
   assign in_column  = data_q;
   assign scroll_ofs = ofs_q;
   assign LOAD       = (state_q == WRITE);
   assign IN_CLR     = (state_q == CLEAR);
   assign frame_done = (state_q == DONE);
   assign busy       = (state_q != IDLE);

endmodule
